// File: rtl/pulse_transmitter_seq_engine_if.sv
// Control, configuration and status bundle between the TinyQV wrapper
// (master) and the pulse sequence engine (slave).
interface pulse_transmitter_seq_engine_if #(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 32,
  parameter int DUR_W   = 16,
  parameter int PRESC_W = 4
);
  localparam int AW = $clog2(DEPTH);

  logic                 start;
  logic                 stop;
  logic                 sym_we;
  logic [AW-1:0]        sym_waddr;
  logic [1:0]           sym_wdata;
  logic [4*NUM_CH-1:0]  slot_level;
  logic [4*DUR_W-1:0]   slot_duration;
  logic [PRESC_W-1:0]   prescaler;
  logic [AW-1:0]        end_index;
  logic [AW-1:0]        loopback_index;
  logic [7:0]           loop_count;
  logic                 loop_forever;
  logic [NUM_CH-1:0]    idle_level;
  logic [NUM_CH-1:0]    invert;
  logic [NUM_CH-1:0]    carrier_en;
  logic [15:0]          carrier_half;

  logic [NUM_CH-1:0]    ch_out;
  logic                 active;
  logic                 busy;
  logic [AW-1:0]        pc;
  logic [7:0]           loops_left;
  logic                 evt_symbol;
  logic                 evt_loop;
  logic                 evt_done;

  modport master (
    output start, stop, sym_we, sym_waddr, sym_wdata, slot_level, slot_duration,
           prescaler, end_index, loopback_index, loop_count, loop_forever,
           idle_level, invert, carrier_en, carrier_half,
    input  ch_out, active, busy, pc, loops_left, evt_symbol, evt_loop, evt_done
  );

  modport slave (
    input  start, stop, sym_we, sym_waddr, sym_wdata, slot_level, slot_duration,
           prescaler, end_index, loopback_index, loop_count, loop_forever,
           idle_level, invert, carrier_en, carrier_half,
    output ch_out, active, busy, pc, loops_left, evt_symbol, evt_loop, evt_done
  );
endinterface

// File: rtl/pulse_transmitter_seq_engine.sv
// Multi-channel pulse sequencer: plays 2-bit slot symbols from a small memory
// with segment looping, per-channel carrier gating, idle level and inversion.
module pulse_transmitter_seq_engine #(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 32,
  parameter int DUR_W   = 16,
  parameter int PRESC_W = 4
) (
  input logic clk,
  input logic rst_n,
  pulse_transmitter_seq_engine_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;

  state_t             state, state_d;
  logic [1:0]         mem [DEPTH];
  logic               primed, primed_d;
  logic [AW-1:0]      pc, pc_d, pc_inc;
  logic [7:0]         loops_left, loops_d;
  logic [1:0]         nxt_sym, nxt_sym_d, load_sym;
  logic               load;
  logic [NUM_CH-1:0]  cur_lvl, lvl_d;
  logic [DUR_W-1:0]   dur_cnt, dur_d;
  logic [PRESC_W-1:0] presc_cnt, presc_d, presc_rl, rl_d;
  logic               carrier, car_d;
  logic [15:0]        car_cnt, car_cnt_d;
  logic               active, active_d;
  logic [NUM_CH-1:0]  ch_out, ch_out_d, car_mask;
  logic               evt_symbol, evt_symbol_d, evt_loop, evt_loop_d, evt_done, evt_done_d;

  // Symbol memory is deliberately unreset; reads see pre-write data on a same-cycle write.
  always_ff @(posedge clk) begin
    if (bus.sym_we) mem[bus.sym_waddr] <= bus.sym_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      primed     <= 1'b0;
      pc         <= '0;
      loops_left <= '0;
      nxt_sym    <= '0;
      cur_lvl    <= '0;
      dur_cnt    <= '0;
      presc_cnt  <= '0;
      presc_rl   <= '0;
      carrier    <= 1'b0;
      car_cnt    <= '0;
      active     <= 1'b0;
      ch_out     <= '0;
      evt_symbol <= 1'b0;
      evt_loop   <= 1'b0;
      evt_done   <= 1'b0;
    end else begin
      state      <= state_d;
      primed     <= primed_d;
      pc         <= pc_d;
      loops_left <= loops_d;
      nxt_sym    <= nxt_sym_d;
      cur_lvl    <= lvl_d;
      dur_cnt    <= dur_d;
      presc_cnt  <= presc_d;
      presc_rl   <= rl_d;
      carrier    <= car_d;
      car_cnt    <= car_cnt_d;
      active     <= active_d;
      ch_out     <= ch_out_d;
      evt_symbol <= evt_symbol_d;
      evt_loop   <= evt_loop_d;
      evt_done   <= evt_done_d;
    end
  end

  always_comb begin
    state_d      = state;
    primed_d     = primed;
    pc_d         = pc;
    loops_d      = loops_left;
    nxt_sym_d    = nxt_sym;
    lvl_d        = cur_lvl;
    dur_d        = dur_cnt;
    presc_d      = presc_cnt;
    rl_d         = presc_rl;
    car_d        = carrier;
    car_cnt_d    = car_cnt;
    active_d     = active;
    evt_symbol_d = 1'b0;
    evt_loop_d   = 1'b0;
    evt_done_d   = 1'b0;
    load         = 1'b0;
    load_sym     = 2'd0;
    pc_inc       = AW'(pc + 1'b1);
    car_mask     = '0;
    ch_out_d     = '0;

    if (state != IDLE) begin
      if (car_cnt == bus.carrier_half) begin
        car_cnt_d = '0;
        car_d     = ~carrier;
      end else begin
        car_cnt_d = car_cnt + 16'd1;
      end
    end

    unique case (state)
      IDLE: begin
        active_d = 1'b0;
        if (bus.start) begin
          state_d   = FETCH;
          primed_d  = 1'b0;
          pc_d      = '0;
          loops_d   = bus.loop_count;
          car_d     = 1'b0;
          car_cnt_d = '0;
        end
      end
      FETCH: begin
        if (!primed) begin
          nxt_sym_d = mem[pc];
          primed_d  = 1'b1;
        end else begin
          load     = 1'b1;
          load_sym = nxt_sym;
          state_d  = RUN;
        end
      end
      RUN: begin
        // A symbol ends only when both the prescaler and duration counters are exhausted.
        if (presc_cnt != '0) begin
          presc_d = presc_cnt - 1'b1;
        end else if (dur_cnt != '0) begin
          dur_d   = dur_cnt - 1'b1;
          presc_d = presc_rl;
        end else if (pc != bus.end_index) begin
          pc_d     = pc_inc;
          load     = 1'b1;
          load_sym = mem[pc_inc];
        end else if (bus.loop_forever || loops_left != 8'd0) begin
          pc_d       = bus.loopback_index;
          load       = 1'b1;
          load_sym   = mem[bus.loopback_index];
          evt_loop_d = 1'b1;
          if (!bus.loop_forever) loops_d = loops_left - 8'd1;
        end else begin
          state_d    = IDLE;
          active_d   = 1'b0;
          evt_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      lvl_d        = bus.slot_level[int'(load_sym)*NUM_CH +: NUM_CH];
      dur_d        = bus.slot_duration[int'(load_sym)*DUR_W +: DUR_W];
      presc_d      = bus.prescaler;
      rl_d         = bus.prescaler;
      active_d     = 1'b1;
      evt_symbol_d = 1'b1;
    end

    // Abort wins over everything, but keeps pc and loops_left for readback.
    if (bus.stop) begin
      state_d      = IDLE;
      pc_d         = pc;
      loops_d      = loops_left;
      active_d     = 1'b0;
      evt_symbol_d = 1'b0;
      evt_loop_d   = 1'b0;
      evt_done_d   = 1'b0;
    end

    car_mask = (bus.carrier_en & {NUM_CH{car_d}}) | ~bus.carrier_en;
    ch_out_d = active_d ? ((lvl_d & car_mask) ^ bus.invert) : (bus.idle_level ^ bus.invert);
  end

  assign bus.ch_out     = ch_out;
  assign bus.active     = active;
  assign bus.busy       = (state != IDLE);
  assign bus.pc         = pc;
  assign bus.loops_left = loops_left;
  assign bus.evt_symbol = evt_symbol;
  assign bus.evt_loop   = evt_loop;
  assign bus.evt_done   = evt_done;
endmodule

// File: tb/tb_pulse_transmitter_seq_engine.sv
// Bench for the pulse sequence engine: directed and randomized sequences
// compared cycle by cycle against a timeline built from the symbol rules.
module tb_pulse_transmitter_seq_engine;
  localparam int NUM_CH  = 2;
  localparam int DEPTH   = 32;
  localparam int DUR_W   = 16;
  localparam int PRESC_W = 4;
  localparam int AW      = $clog2(DEPTH);
  localparam int MAXT    = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulse_transmitter_seq_engine_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DUR_W(DUR_W), .PRESC_W(PRESC_W)) bus();

  pulse_transmitter_seq_engine #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DUR_W(DUR_W), .PRESC_W(PRESC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [1:0]        model_mem [DEPTH];
  logic [NUM_CH-1:0] lvl [4];
  int                dur [4];
  int                presc, end_i, lb_i, lc, half;
  logic              fe;
  logic [NUM_CH-1:0] idle_l, inv, cen;

  logic [NUM_CH-1:0] exp_ch    [MAXT];
  logic [4:0]        exp_flags [MAXT];
  logic [AW+7:0]     exp_pl    [MAXT];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus();
    for (int s = 0; s < 4; s++) begin
      bus.slot_level[s*NUM_CH +: NUM_CH]  = lvl[s];
      bus.slot_duration[s*DUR_W +: DUR_W] = DUR_W'(dur[s]);
    end
    bus.prescaler      = PRESC_W'(presc);
    bus.end_index      = AW'(end_i);
    bus.loopback_index = AW'(lb_i);
    bus.loop_count     = 8'(lc);
    bus.loop_forever   = fe;
    bus.idle_level     = idle_l;
    bus.invert         = inv;
    bus.carrier_en     = cen;
    bus.carrier_half   = 16'(half);
  endtask

  task automatic writeMem(input int a, input logic [1:0] d);
    @(negedge clk);
    bus.sym_we    = 1'b1;
    bus.sym_waddr = AW'(a);
    bus.sym_wdata = d;
    @(negedge clk);
    bus.sym_we    = 1'b0;
    model_mem[a]  = d;
  endtask

  // Timeline indexed by clocks after the start edge: entry t is what the outputs
  // should hold right after edge k+t. Symbols follow the pc walk of the segment rules.
  task automatic buildExpected(output int n);
    int t, p, loops, s, len;
    logic lp, car;
    logic [NUM_CH-1:0] mk;
    for (int i = 0; i < 2; i++) begin
      exp_ch[i]    = idle_l ^ inv;
      exp_flags[i] = 5'b01000;
      exp_pl[i]    = {AW'(0), 8'(lc)};
    end
    t = 2; p = 0; loops = lc; lp = 1'b0;
    forever begin
      s   = int'(model_mem[p]);
      len = (dur[s] + 1) * (presc + 1);
      for (int i = 0; i < len && (t + i) < MAXT - 2; i++) begin
        car = (((t + i) / (half + 1)) % 2) == 1;
        mk  = car ? {NUM_CH{1'b1}} : ~cen;
        exp_ch[t+i]    = (lvl[s] & mk) ^ inv;
        exp_flags[t+i] = {1'b1, 1'b1, i == 0, (i == 0) && lp, 1'b0};
        exp_pl[t+i]    = {AW'(p), 8'(loops)};
      end
      t = t + len;
      if (t >= MAXT - 2) begin
        t = MAXT - 2;
        break;
      end
      if (p != end_i) begin
        p  = (p + 1) % DEPTH;
        lp = 1'b0;
      end else if (loops > 0) begin
        p     = lb_i;
        loops = loops - 1;
        lp    = 1'b1;
      end else begin
        break;
      end
    end
    exp_ch[t]      = idle_l ^ inv;
    exp_flags[t]   = 5'b00001;
    exp_pl[t]      = {AW'(p), 8'(loops)};
    exp_ch[t+1]    = idle_l ^ inv;
    exp_flags[t+1] = 5'b00000;
    exp_pl[t+1]    = {AW'(p), 8'(loops)};
    n = t;
  endtask

  task automatic runScenario(input string name);
    int n;
    applyStimulus();
    buildExpected(n);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int t = 0; t <= n + 1; t++) begin
      checkOutput($sformatf("%s t=%0d ch_out", name, t), 32'(bus.ch_out), 32'(exp_ch[t]));
      checkOutput($sformatf("%s t=%0d act/busy/evt", name, t),
                  32'({bus.active, bus.busy, bus.evt_symbol, bus.evt_loop, bus.evt_done}), 32'(exp_flags[t]));
      checkOutput($sformatf("%s t=%0d pc/loops", name, t), 32'({bus.pc, bus.loops_left}), 32'(exp_pl[t]));
      @(negedge clk);
    end
  endtask

  task automatic setBasic();
    lvl[0] = 2'b01; dur[0] = 2;
    lvl[1] = 2'b10; dur[1] = 4;
    lvl[2] = 2'b00; dur[2] = 0;
    lvl[3] = 2'b11; dur[3] = 0;
    presc = 0; end_i = 1; lb_i = 0; lc = 0; fe = 1'b0; half = 0;
    idle_l = 2'b00; inv = 2'b00; cen = 2'b00;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.sym_we = 1'b0;
    bus.sym_waddr = '0; bus.sym_wdata = '0;
    setBasic();
    applyStimulus();

    #12;
    checkOutput("reset ch_out", 32'(bus.ch_out), 32'd0);
    checkOutput("reset status", 32'({bus.active, bus.busy, bus.evt_symbol, bus.evt_loop, bus.evt_done}), 32'd0);
    checkOutput("reset pc/loops", 32'({bus.pc, bus.loops_left}), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) writeMem(a, 2'($urandom));
    writeMem(0, 2'd0);
    writeMem(1, 2'd1);

    setBasic();
    runScenario("basic");

    // Loop segment 1..2 taken twice, all one-clock symbols.
    writeMem(2, 2'd2);
    setBasic();
    dur[0] = 0; dur[1] = 0; dur[2] = 0; dur[3] = 0;
    end_i = 2; lb_i = 1; lc = 2;
    runScenario("loop");

    setBasic();
    presc = 3; dur[0] = 1; dur[1] = 1;
    runScenario("prescaler");

    setBasic();
    lvl[0] = 2'b11; dur[0] = 9; end_i = 0;
    cen = 2'b01; half = 1; inv = 2'b10; idle_l = 2'b01;
    runScenario("carrier");

    // Segment wraps through DEPTH-1 back to 0.
    setBasic();
    dur[0] = 1; dur[1] = 0; dur[2] = 0; dur[3] = 1;
    end_i = 1; lb_i = DEPTH - 2; lc = 1;
    runScenario("wrap");

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) writeMem($urandom_range(0, DEPTH - 1), 2'($urandom));
      for (int s = 0; s < 4; s++) begin
        lvl[s] = NUM_CH'($urandom);
        dur[s] = $urandom_range(0, 4);
      end
      presc  = $urandom_range(0, 3);
      end_i  = $urandom_range(0, 6);
      lb_i   = $urandom_range(0, DEPTH - 1);
      lc     = $urandom_range(0, 2);
      fe     = 1'b0;
      half   = $urandom_range(0, 3);
      idle_l = NUM_CH'($urandom);
      inv    = NUM_CH'($urandom);
      cen    = NUM_CH'($urandom);
      runScenario($sformatf("rand%0d", r));
    end

    // Abort a forever loop mid-symbol.
    setBasic();
    dur[0] = 3; dur[1] = 3; presc = 1; fe = 1'b1; lc = 5; idle_l = 2'b10; inv = 2'b01;
    applyStimulus();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("abort pre busy", 32'(bus.busy), 32'd1);
    bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
    checkOutput("abort ch_out", 32'(bus.ch_out), 32'(idle_l ^ inv));
    checkOutput("abort status", 32'({bus.active, bus.busy, bus.evt_done}), 32'd0);
    checkOutput("abort loops_left", 32'(bus.loops_left), 32'd5);
    @(negedge clk);
    checkOutput("abort no done", 32'({bus.busy, bus.evt_done}), 32'd0);

    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk) begin bus.start = 1'b0; bus.stop = 1'b0; end
    checkOutput("start+stop busy", 32'({bus.active, bus.busy}), 32'd0);
    @(negedge clk);
    checkOutput("start+stop idle ch", 32'(bus.ch_out), 32'(idle_l ^ inv));

    // Asynchronous reset mid-run.
    setBasic();
    idle_l = 2'b01; inv = 2'b10;
    applyStimulus();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst ch_out", 32'(bus.ch_out), 32'd0);
    checkOutput("async rst status", 32'({bus.active, bus.busy, bus.evt_symbol, bus.evt_loop, bus.evt_done}), 32'd0);
    checkOutput("async rst pc/loops", 32'({bus.pc, bus.loops_left}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post rst idle busy", 32'(bus.busy), 32'd0);
      checkOutput("post rst idle ch", 32'(bus.ch_out), 32'(idle_l ^ inv));
    end
    runScenario("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
